zbt_pixel_writer: RTL
=====================

ZBT_PIXEL_WRITER -- requirements
Module: zbt_pixel_writer

Interface
REQ-001 Parameters SHALL be: FRAME_W, 800, pixels per line; FRAME_H, 600, lines per frame; FIFO_DEPTH, 4, request buffer entries; STALL_LIMIT, 1023, blocked cycles before stall_err.
REQ-002 clk  input  1  system clock; the only clock in the block.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-004 in_valid  input  1  a pixel write request is present.
REQ-005 in_ready  output  1  request accepted on a clk edge where in_valid and in_ready are both 1.
REQ-006 in_x  input  11  pixel column; in_y  input  10  pixel row; in_pixel  input  16  pixel value.
REQ-007 display_req  input  1  display reader owns the ZBT port this cycle.
REQ-008 flush  input  1  synchronous discard of all buffered requests.
REQ-009 zbt_we  output  1  write strobe to the ZBT controller.
REQ-010 zbt_addr  output  19  write address; zbt_wdata  output  36  write data.
REQ-011 busy  output  1  FIFO not empty or a write is being issued.
REQ-012 drop_count  output  8  saturating count of out-of-range requests.
REQ-013 stall_err  output  1  sticky flag: the block was blocked for too long.

Function
REQ-014 in_ready SHALL equal (FIFO count < FIFO_DEPTH), combinational from registered count only.
REQ-015 An accepted request with in_x >= FRAME_W or in_y >= FRAME_H SHALL NOT enter the FIFO and SHALL increment drop_count, saturating at 255.
REQ-016 An accepted in-range request SHALL enter the FIFO on the accepting edge N.
REQ-017 The head SHALL pop on edge N+1 at the earliest, and only when display_req=0 and FIFO is non-empty at that edge.
REQ-018 On the edge after a pop, zbt_we=1 for exactly one cycle, zbt_addr = in_y*FRAME_W + in_x (19-bit, no overflow for legal coordinates), zbt_wdata = {20'b0, in_pixel}; total accept-to-strobe latency 2 edges minimum.
REQ-019 When display_req=1, zbt_we SHALL be 0 in the following cycle; at most one write per cycle.
REQ-020 A simultaneous push and pop SHALL keep count unchanged; a full FIFO with a pop SHALL assert in_ready on the next cycle.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; write order SHALL equal acceptance order.
REQ-022 FSM states: IDLE (empty), ISSUE (non-empty, display_req=0), BLOCKED (non-empty, display_req=1). IDLE->ISSUE/BLOCKED on push; ISSUE<->BLOCKED following display_req; ->IDLE when the last entry pops.
REQ-023 The BLOCKED dwell counter SHALL clear on leaving BLOCKED; reaching STALL_LIMIT SHALL set stall_err until reset.
REQ-024 flush SHALL empty the FIFO, return the FSM to IDLE, and win over same-cycle push and pop. A write already strobed completes, and a request accepted in that cycle is discarded.
REQ-025 drop_count and stall_err SHALL be unaffected by flush.

Reset
REQ-026 While reset=0, all state SHALL be cleared asynchronously: FIFO empty, FSM IDLE, zbt_we=0, zbt_addr=0, zbt_wdata=0, busy=0, drop_count=0, stall_err=0, in_ready=1.
REQ-027 Reset mid-operation SHALL discard buffered requests without issuing a partial write; operation resumes on the first clk edge after reset returns to 1.

Structure
REQ-028 FRAME_W, FRAME_H, ZBT address/data widths and FSM state encodings SHALL reside in a shared package used by the display reader and the image initializer.
REQ-029 The FIFO SHALL be one sub-module, pixel_req_fifo (parameterized depth and width, with count output); FSM, address multiply and output registers stay in zbt_pixel_writer.

Verification
REQ-030 Single request (x=5, y=2, pixel=16'hABCD) with display_req=0 -> zbt_we one cycle, 2 edges after acceptance; addr=1605; wdata=36'h00000ABCD.
REQ-031 Five back-to-back requests with display_req=1 -> in_ready low after the 4th; on release, 4 writes issue in order on consecutive cycles, and the 5th is then accepted.
REQ-032 Request x=800, y=0, then x=0, y=600 -> no zbt_we; drop_count=2; 300 further bad requests -> drop_count=255.
REQ-033 display_req held 1 with 1 entry for 1023+ cycles -> stall_err=1 and stays 1 after display_req falls; write then issues.
REQ-034 3 entries queued, flush asserted together with in_valid -> FIFO empty, busy=0 next cycle, no further zbt_we.
REQ-035 reset pulsed low asynchronously with 2 entries queued -> outputs go to reset values immediately and no write follows.

Source files
------------

// File: rtl/zbt_pixel_writer_pkg.sv
// Shared ZBT frame-buffer definitions: frame geometry, bus widths,
// writer FSM encoding and the pixel request bundle.
package zbt_pixel_writer_pkg;

    localparam int FRAME_W = 800;
    localparam int FRAME_H = 600;

    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int PIX_W  = 16;
    localparam int ZBT_AW = 19;
    localparam int ZBT_DW = 36;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BLOCKED = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [PIX_W-1:0] pixel;
    } pix_req_t;

    function automatic logic [ZBT_DW-1:0] zbt_word(
        input logic [PIX_W-1:0] pixel
    );
        return {{(ZBT_DW - PIX_W){1'b0}}, pixel};
    endfunction

endpackage

// File: rtl/pixel_req_fifo.sv
// Small synchronous request FIFO with occupancy count and a
// flush that overrides push and pop.
module pixel_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/zbt_pixel_writer.sv
// Buffers pixel writes and issues them to the shared ZBT port
// whenever the display reader does not own it.
module zbt_pixel_writer #(
    parameter int FRAME_W     = zbt_pixel_writer_pkg::FRAME_W,
    parameter int FRAME_H     = zbt_pixel_writer_pkg::FRAME_H,
    parameter int FIFO_DEPTH  = 4,
    parameter int STALL_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_x,
    input  logic [9:0]  in_y,
    input  logic [15:0] in_pixel,
    input  logic        display_req,
    input  logic        flush,
    output logic        zbt_we,
    output logic [18:0] zbt_addr,
    output logic [35:0] zbt_wdata,
    output logic        busy,
    output logic [7:0]  drop_count,
    output logic        stall_err
);

    import zbt_pixel_writer_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    localparam logic [X_W-1:0]    FW_X = X_W'(FRAME_W);
    localparam logic [Y_W-1:0]    FH_Y = Y_W'(FRAME_H);
    localparam logic [ZBT_AW-1:0] FW_A = ZBT_AW'(FRAME_W);

    wr_state_t         state_q;
    wr_state_t         state_d;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [SW-1:0]     dwell_q;
    logic [SW-1:0]     dwell_d;
    pix_req_t          in_req;
    pix_req_t          head;
    pix_req_t          stg_req;
    logic              stg_vld;
    logic [ZBT_AW-1:0] stg_addr;
    logic              accept;
    logic              in_range;
    logic              push;
    logic              pop;
    logic              issue;
    logic              go_idle;

    assign in_ready = count < CW'(FIFO_DEPTH);
    assign accept   = in_valid && in_ready;
    assign in_range = (in_x < FW_X) && (in_y < FH_Y);
    assign push     = accept && in_range && !flush;
    assign pop      = (count != '0) && !display_req && !flush;
    assign issue    = stg_vld && !display_req && !flush;
    assign busy     = (count != '0) || stg_vld;

    assign in_req = '{x: in_x, y: in_y, pixel: in_pixel};

    // Address multiply sits between the pop stage and the output registers.
    assign stg_addr = ZBT_AW'(stg_req.y) * FW_A + ZBT_AW'(stg_req.x);

    pixel_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_req_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_req),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        count_next = count;
        state_d    = state_q;
        dwell_d    = '0;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
        go_idle = flush || (count_next == '0);
        unique case (1'b1)
            go_idle:                 state_d = ST_IDLE;
            !go_idle && display_req:  state_d = ST_BLOCKED;
            !go_idle && !display_req: state_d = ST_ISSUE;
        endcase
        if (state_q == ST_BLOCKED && state_d == ST_BLOCKED) begin
            dwell_d = (dwell_q == SW'(STALL_LIMIT)) ? dwell_q : dwell_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_err  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (dwell_d == SW'(STALL_LIMIT)) begin
                stall_err <= 1'b1;
            end
            if (accept && !in_range && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // A popped entry waits here while the display reader owns the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_vld <= 1'b0;
            stg_req <= '0;
        end else if (flush) begin
            stg_vld <= 1'b0;
        end else if (pop) begin
            stg_vld <= 1'b1;
            stg_req <= head;
        end else if (issue) begin
            stg_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zbt_we    <= 1'b0;
            zbt_addr  <= '0;
            zbt_wdata <= '0;
        end else begin
            zbt_we <= issue;
            if (issue) begin
                zbt_addr  <= stg_addr;
                zbt_wdata <= zbt_word(stg_req.pixel);
            end
        end
    end

endmodule
